quadrature_oscillator_seq: RTL and testbench

QUADRATURE_OSCILLATOR_SEQ -- requirements
Module: quadrature_oscillator_seq

---
 rtl/quadrature_oscillator_seq.sv | 171 +++++++++++++++++
 tb/tb_quadrature_oscillator_seq.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/quadrature_oscillator_seq.sv
// Sequential quadrature oscillator: one shared signed multiplier steps through eight
// products per iteration to rotate (accu_re, accu_im) and optionally correct its power.
module quadrature_oscillator_seq #(
    parameter int WIDTH   = 16,
    parameter int CORR_EN = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic                    step,
    input  logic                    run,
    input  logic signed [WIDTH-1:0] re_coeff,
    input  logic signed [WIDTH-1:0] im_coeff,
    input  logic signed [WIDTH-1:0] power,
    input  logic signed [WIDTH-1:0] accu_re_init,
    input  logic signed [WIDTH-1:0] accu_im_init,
    output logic signed [WIDTH-1:0] accu_re,
    output logic signed [WIDTH-1:0] accu_im,
    output logic                    out_valid,
    output logic                    busy,
    output logic                    sat_flag
);
    localparam int FRAC = WIDTH - 1;
    localparam int ACC  = 2 * WIDTH + 4;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_UPD = 2'd2} state_t;

    state_t                  state_r, state_s;
    logic [2:0]              cnt_r;
    logic signed [WIDTH-1:0] c_re_r, c_im_r, pow_r;
    logic signed [ACC-1:0]   temp_re_r, temp_im_r, pw_r, sum_re_r, sum_im_r;
    logic signed [ACC-1:0]   tr_s, ti_s, t0_s, mul_a_s, mul_b_s, prod_s, pow_sh_s;
    logic signed [WIDTH-1:0] new_re_s, new_im_s;
    logic                    clip_re_s, clip_im_s;

    function automatic logic signed [ACC-1:0] sext(input logic signed [WIDTH-1:0] v);
        return {{(ACC-WIDTH){v[WIDTH-1]}}, v};
    endfunction

    // Symmetric clamp to +/-(2^(WIDTH-1)-1); MSB of the result flags a clamp.
    function automatic logic [WIDTH:0] saturate(input logic signed [ACC-1:0] v);
        logic signed [ACC-1:0] hi;
        logic signed [ACC-1:0] lo;
        hi = {{(ACC-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
        lo = -hi;
        if (v > hi) begin
            return {1'b1, hi[WIDTH-1:0]};
        end else if (v < lo) begin
            return {1'b1, lo[WIDTH-1:0]};
        end else begin
            return {1'b0, v[WIDTH-1:0]};
        end
    endfunction

    // Derived terms, shared-multiplier operand select and saturated update values.
    always_comb begin
        tr_s     = temp_re_r >>> FRAC;
        ti_s     = temp_im_r >>> FRAC;
        pow_sh_s = sext(pow_r) <<< WIDTH;
        if (CORR_EN != 0) begin
            t0_s = pw_r >>> WIDTH;
        end else begin
            t0_s = {ACC{1'b0}};
        end
        mul_a_s = {ACC{1'b0}};
        mul_b_s = {ACC{1'b0}};
        case (cnt_r)
            3'd0:    begin mul_a_s = sext(accu_re); mul_b_s = sext(c_re_r); end
            3'd1:    begin mul_a_s = sext(accu_im); mul_b_s = sext(c_im_r); end
            3'd2:    begin mul_a_s = sext(accu_re); mul_b_s = sext(c_im_r); end
            3'd3:    begin mul_a_s = sext(accu_im); mul_b_s = sext(c_re_r); end
            3'd4:    begin mul_a_s = tr_s;          mul_b_s = tr_s;         end
            3'd5:    begin mul_a_s = ti_s;          mul_b_s = ti_s;         end
            3'd6:    begin mul_a_s = tr_s;          mul_b_s = t0_s;         end
            3'd7:    begin mul_a_s = ti_s;          mul_b_s = t0_s;         end
            default: begin mul_a_s = {ACC{1'b0}};   mul_b_s = {ACC{1'b0}};  end
        endcase
        prod_s = mul_a_s * mul_b_s;
        {clip_re_s, new_re_s} = saturate(sum_re_r >>> FRAC);
        {clip_im_s, new_im_s} = saturate(sum_im_r >>> FRAC);
    end

    // Next-state logic; load is resolved in the register process with higher priority.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (step || run) begin
                    state_s = S_MUL;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_MUL: begin
                if (cnt_r == 3'd7) begin
                    state_s = S_UPD;
                end else begin
                    state_s = S_MUL;
                end
            end
            S_UPD:   state_s = S_IDLE;
            default: state_s = S_IDLE;
        endcase
    end

    // State, datapath accumulators and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= S_IDLE;
            cnt_r     <= 3'd0;
            c_re_r    <= {WIDTH{1'b0}};
            c_im_r    <= {WIDTH{1'b0}};
            pow_r     <= {WIDTH{1'b0}};
            temp_re_r <= {ACC{1'b0}};
            temp_im_r <= {ACC{1'b0}};
            pw_r      <= {ACC{1'b0}};
            sum_re_r  <= {ACC{1'b0}};
            sum_im_r  <= {ACC{1'b0}};
            accu_re   <= {WIDTH{1'b0}};
            accu_im   <= {WIDTH{1'b0}};
            out_valid <= 1'b0;
            busy      <= 1'b0;
            sat_flag  <= 1'b0;
        end else if (load) begin
            state_r   <= S_IDLE;
            cnt_r     <= 3'd0;
            accu_re   <= accu_re_init;
            accu_im   <= accu_im_init;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            sat_flag  <= 1'b0;
        end else begin
            state_r   <= state_s;
            out_valid <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (step || run) begin
                        c_re_r <= re_coeff;
                        c_im_r <= im_coeff;
                        pow_r  <= power;
                        busy   <= 1'b1;
                        cnt_r  <= 3'd0;
                    end
                end
                S_MUL: begin
                    cnt_r <= cnt_r + 3'd1;
                    case (cnt_r)
                        3'd0:    temp_re_r <= prod_s;
                        3'd1:    temp_re_r <= temp_re_r - prod_s;
                        3'd2:    temp_im_r <= prod_s;
                        3'd3:    temp_im_r <= temp_im_r + prod_s;
                        3'd4:    pw_r      <= pow_sh_s - prod_s;
                        3'd5:    pw_r      <= pw_r - prod_s;
                        3'd6:    sum_re_r  <= temp_re_r + prod_s;
                        3'd7:    sum_im_r  <= temp_im_r + prod_s;
                        default: pw_r      <= pw_r;
                    endcase
                end
                S_UPD: begin
                    accu_re   <= new_re_s;
                    accu_im   <= new_im_s;
                    out_valid <= 1'b1;
                    busy      <= 1'b0;
                    cnt_r     <= 3'd0;
                    sat_flag  <= sat_flag | clip_re_s | clip_im_s;
                end
                default: state_r <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_quadrature_oscillator_seq.sv
// Scoreboard bench: two instances (correction off / on) share stimulus; expected
// results come from a wide-integer reference model queued at each accepted iteration.
module tb_quadrature_oscillator_seq;
    logic clk = 1'b0;
    logic rst, load, step, run;
    logic signed [15:0] re_coeff, im_coeff, power, accu_re_init, accu_im_init;
    logic signed [15:0] acc_re [2];
    logic signed [15:0] acc_im [2];
    logic ov [2];
    logic bz [2];
    logic sf [2];

    int total = 0;
    int bad = 0;
    longint m_re [2];
    longint m_im [2];
    bit m_sat [2];
    logic [32:0] q0 [$];
    logic [32:0] q1 [$];

    always #5 clk = ~clk;

    quadrature_oscillator_seq #(.WIDTH(16), .CORR_EN(0)) d0 (
        .clk(clk), .rst(rst), .load(load), .step(step), .run(run),
        .re_coeff(re_coeff), .im_coeff(im_coeff), .power(power),
        .accu_re_init(accu_re_init), .accu_im_init(accu_im_init),
        .accu_re(acc_re[0]), .accu_im(acc_im[0]), .out_valid(ov[0]),
        .busy(bz[0]), .sat_flag(sf[0]));

    quadrature_oscillator_seq #(.WIDTH(16), .CORR_EN(1)) d1 (
        .clk(clk), .rst(rst), .load(load), .step(step), .run(run),
        .re_coeff(re_coeff), .im_coeff(im_coeff), .power(power),
        .accu_re_init(accu_re_init), .accu_im_init(accu_im_init),
        .accu_re(acc_re[1]), .accu_im(acc_im[1]), .out_valid(ov[1]),
        .busy(bz[1]), .sat_flag(sf[1]));

    function automatic logic [32:0] model(input longint re, input longint im, input longint cre,
                                          input longint cim, input longint pw, input bit corr);
        longint tre, tim, tr, ti, t0, nre, nim;
        bit c;
        c   = 1'b0;
        tre = re * cre - im * cim;
        tim = re * cim + im * cre;
        tr  = tre >>> 15;
        ti  = tim >>> 15;
        t0  = corr ? (((pw <<< 16) - tr * tr - ti * ti) >>> 16) : 64'sd0;
        nre = (tre + tr * t0) >>> 15;
        nim = (tim + ti * t0) >>> 15;
        if (nre > 32767)  begin nre = 32767;  c = 1'b1; end
        if (nre < -32767) begin nre = -32767; c = 1'b1; end
        if (nim > 32767)  begin nim = 32767;  c = 1'b1; end
        if (nim < -32767) begin nim = -32767; c = 1'b1; end
        return {c, nre[15:0], nim[15:0]};
    endfunction

    task automatic push_expect();
        q0.push_back(model(m_re[0], m_im[0], re_coeff, im_coeff, power, 1'b0));
        q1.push_back(model(m_re[1], m_im[1], re_coeff, im_coeff, power, 1'b1));
    endtask

    task automatic do_load(input logic signed [15:0] ire, input logic signed [15:0] iim);
        accu_re_init = ire; accu_im_init = iim; load = 1'b1;
        @(posedge clk); #1 load = 1'b0;
        for (int i = 0; i < 2; i++) begin
            m_re[i] = ire; m_im[i] = iim; m_sat[i] = 1'b0;
        end
        q0.delete(); q1.delete();
    endtask

    // One step pulse; lat = edges from accept to out_valid (-1 on timeout).
    task automatic run_step(output int lat, output bit bsy_start, output bit bsy_end);
        push_expect();
        step = 1'b1;
        @(posedge clk); #1 step = 1'b0;
        @(negedge clk); bsy_start = bz[0];
        lat = -1; bsy_end = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); @(negedge clk);
            if (ov[0]) begin lat = k; bsy_end = bz[0]; break; end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; load = 1'b0; step = 1'b0; run = 1'b0;
        re_coeff = 16'sd0; im_coeff = 16'sd0; power = 16'sd0;
        accu_re_init = 16'sd0; accu_im_init = 16'sd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            total++; if (acc_re[i] !== 16'sd0) begin bad++; $display("FAIL reset_re[%0d]: got %0d want 0", i, acc_re[i]); end
            total++; if (acc_im[i] !== 16'sd0) begin bad++; $display("FAIL reset_im[%0d]: got %0d want 0", i, acc_im[i]); end
            total++; if ({ov[i], bz[i], sf[i]} !== 3'b000) begin bad++; $display("FAIL reset_flags[%0d]: got %b want 000", i, {ov[i], bz[i], sf[i]}); end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_rotate90();
        int lat; bit b0, b1; logic [32:0] e;
        do_load(16'sd16384, 16'sd0);
        re_coeff = 16'sd0; im_coeff = 16'sd32767; power = 16'sd0;
        run_step(lat, b0, b1);
        total++; if (lat !== 9) begin bad++; $display("FAIL rot_latency: got %0d want 9", lat); end
        total++; if ({b0, b1} !== 2'b10) begin bad++; $display("FAIL rot_busy: got %b want 10", {b0, b1}); end
        total++; if (acc_re[0] !== 16'sd0) begin bad++; $display("FAIL rot_re: got %0d want 0", acc_re[0]); end
        total++; if (acc_im[0] !== 16'sd16383) begin bad++; $display("FAIL rot_im: got %0d want 16383", acc_im[0]); end
        total++; if (sf[0] !== 1'b0) begin bad++; $display("FAIL rot_sat: got %b want 0", sf[0]); end
        e = q1.pop_front();
        total++; if ({acc_re[1], acc_im[1]} !== e[31:0]) begin bad++; $display("FAIL rot_corr: got %0d,%0d want %0d,%0d", acc_re[1], acc_im[1], $signed(e[31:16]), $signed(e[15:0])); end
    endtask

    task automatic test_corr_null();
        int lat; bit b0, b1; logic [32:0] e;
        do_load(16'sd16384, 16'sd0);
        re_coeff = 16'sd32767; im_coeff = 16'sd0; power = 16'sd4096;
        run_step(lat, b0, b1);
        total++; if (acc_re[1] !== 16'sd16383) begin bad++; $display("FAIL null_re: got %0d want 16383", acc_re[1]); end
        total++; if (acc_im[1] !== 16'sd0) begin bad++; $display("FAIL null_im: got %0d want 0", acc_im[1]); end
        total++; if (sf[1] !== 1'b0) begin bad++; $display("FAIL null_sat: got %b want 0", sf[1]); end
        e = q0.pop_front();
        total++; if ({acc_re[0], acc_im[0]} !== e[31:0]) begin bad++; $display("FAIL null_nocorr: got %0d,%0d want %0d,%0d", acc_re[0], acc_im[0], $signed(e[31:16]), $signed(e[15:0])); end
    endtask

    task automatic test_saturation();
        int lat; bit b0, b1; logic [32:0] e;
        do_load(16'sd32767, 16'sd32767);
        re_coeff = 16'sd32767; im_coeff = 16'sd32767; power = 16'sd0;
        run_step(lat, b0, b1);
        total++; if (acc_re[0] !== 16'sd0) begin bad++; $display("FAIL sat_re: got %0d want 0", acc_re[0]); end
        total++; if (acc_im[0] !== 16'sd32767) begin bad++; $display("FAIL sat_im: got %0d want 32767", acc_im[0]); end
        total++; if (sf[0] !== 1'b1) begin bad++; $display("FAIL sat_flag: got %b want 1", sf[0]); end
        e = q0.pop_front();
        m_re[0] = $signed(e[31:16]); m_im[0] = $signed(e[15:0]); m_sat[0] = m_sat[0] | e[32];
        re_coeff = 16'sd16384; im_coeff = 16'sd0;
        run_step(lat, b0, b1);
        e = q0.pop_front();
        total++; if ({acc_re[0], acc_im[0]} !== e[31:0]) begin bad++; $display("FAIL sat_next: got %0d,%0d want %0d,%0d", acc_re[0], acc_im[0], $signed(e[31:16]), $signed(e[15:0])); end
        total++; if (sf[0] !== (m_sat[0] | e[32])) begin bad++; $display("FAIL sat_sticky: got %b want %b", sf[0], m_sat[0] | e[32]); end
        do_load(16'sd0, 16'sd0);
        @(negedge clk);
        total++; if (sf[0] !== 1'b0) begin bad++; $display("FAIL sat_cleared: got %b want 0", sf[0]); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int lat; bit b0, b1; logic [32:0] e;
        do_load(16'sd32767, 16'sd32767);
        re_coeff = 16'sd32767; im_coeff = 16'sd32767; power = 16'sd0;
        run_step(lat, b0, b1);
        total++; if (sf[0] !== 1'b1) begin bad++; $display("FAIL rmid_presat: got %b want 1", sf[0]); end
        step = 1'b1;
        @(posedge clk); #1 step = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            total++; if ({acc_re[i], acc_im[i]} !== 32'd0) begin bad++; $display("FAIL rmid_accu[%0d]: got %0d,%0d want 0,0", i, acc_re[i], acc_im[i]); end
            total++; if ({ov[i], bz[i], sf[i]} !== 3'b000) begin bad++; $display("FAIL rmid_flags[%0d]: got %b want 000", i, {ov[i], bz[i], sf[i]}); end
        end
        for (int i = 0; i < 2; i++) begin m_re[i] = 0; m_im[i] = 0; m_sat[i] = 1'b0; end
        q0.delete(); q1.delete();
        @(posedge clk); #1;
        run_step(lat, b0, b1);
        total++; if (lat !== 9 || b0 !== 1'b1) begin bad++; $display("FAIL rmid_restart: got lat=%0d busy=%b want lat=9 busy=1", lat, b0); end
        e = q0.pop_front();
        total++; if ({acc_re[0], acc_im[0]} !== e[31:0]) begin bad++; $display("FAIL rmid_result: got %0d,%0d want %0d,%0d", acc_re[0], acc_im[0], $signed(e[31:16]), $signed(e[15:0])); end
    endtask

    task automatic test_abort();
        int seen;
        do_load(16'sd5000, -16'sd3000);
        re_coeff = 16'sd20000; im_coeff = 16'sd9000; power = 16'sd2000;
        step = 1'b1;
        @(posedge clk); #1 step = 1'b0;
        @(negedge clk);
        total++; if (bz[0] !== 1'b1) begin bad++; $display("FAIL abort_busy_e0: got %b want 1", bz[0]); end
        repeat (3) @(posedge clk);
        #1 accu_re_init = 16'sd100; accu_im_init = -16'sd100; load = 1'b1;
        @(posedge clk); #1 load = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            total++; if (bz[i] !== 1'b0) begin bad++; $display("FAIL abort_busy[%0d]: got %b want 0", i, bz[i]); end
            total++; if (acc_re[i] !== 16'sd100 || acc_im[i] !== -16'sd100) begin bad++; $display("FAIL abort_accu[%0d]: got %0d,%0d want 100,-100", i, acc_re[i], acc_im[i]); end
        end
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); @(negedge clk);
            if (ov[0] || ov[1]) seen++;
        end
        total++; if (seen !== 0) begin bad++; $display("FAIL abort_no_valid: got %0d pulses want 0", seen); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [32:0] e;
        bit exp_ov;
        do_load(16'sd20000, -16'sd5000);
        re_coeff = 16'sd30000; im_coeff = 16'sd12000; power = 16'sd8000;
        run = 1'b1;
        for (int cyc = 0; cyc < 50; cyc++) begin
            @(posedge clk);
            if (cyc % 10 == 0) push_expect();
            #1;
            if (cyc == 13) begin re_coeff = 16'sd25000; im_coeff = -16'sd20000; end
            if (cyc == 49) run = 1'b0;
            @(negedge clk);
            exp_ov = (cyc % 10 == 9);
            for (int i = 0; i < 2; i++) begin
                total++; if (ov[i] !== exp_ov) begin bad++; $display("FAIL run_valid[%0d] cyc %0d: got %b want %b", i, cyc, ov[i], exp_ov); end
                if (ov[i] === 1'b1) begin
                    if ((i == 0 ? q0.size() : q1.size()) == 0) begin
                        total++; bad++; $display("FAIL run_queue[%0d]: got empty want entry", i);
                    end else begin
                        e = (i == 0) ? q0.pop_front() : q1.pop_front();
                        total++; if ({acc_re[i], acc_im[i]} !== e[31:0]) begin bad++; $display("FAIL run_accu[%0d] cyc %0d: got %0d,%0d want %0d,%0d", i, cyc, acc_re[i], acc_im[i], $signed(e[31:16]), $signed(e[15:0])); end
                        m_sat[i] = m_sat[i] | e[32];
                        total++; if (sf[i] !== m_sat[i]) begin bad++; $display("FAIL run_sat[%0d]: got %b want %b", i, sf[i], m_sat[i]); end
                        m_re[i] = $signed(e[31:16]); m_im[i] = $signed(e[15:0]);
                    end
                end
            end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_rotate90();
        test_corr_null();
        test_saturation();
        test_reset_mid();
        test_abort();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
